// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl
//   Central pipeline hold/flush controller. Arbitrates a taken redirect from
//   ex, multi-cycle ex operations and bus wait into one prioritised hold
//   level, sequences the front-end flush after a redirect, and keeps
//   saturating stall/flush performance counters.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | normal flow; only bus_hold_i can stall (HOLD_PC)
//   FLUSH | front end flushed after a redirect (HOLD_IF), counting down
//   BUSY  | ex is running a multi-cycle op (HOLD_ID) until ex_busy_i drops
//
// Ports
//   clk, rst         core clock, async active-low reset
//   jump_flag_i/addr taken redirect from ex and its target
//   ex_busy_i        multi-cycle op in progress in ex
//   bus_hold_i       fetch/data bus not ready
//   hold_flag_o      hold level: 0 none, 1 pc, 2 if_id, 3 id_ex
//   jump_flag_o/addr redirect forwarded to pc_reg
//   flush_active_o   high while in FLUSH
//   stall_cnt_o      cycles with a non-zero hold level (saturating)
//   flush_cnt_o      accepted redirects (saturating)
module pipe_hold_ctrl #(
    parameter int unsigned HOLD_W       = 3,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              ex_busy_i,
    input  logic              bus_hold_i,
    output logic [HOLD_W-1:0] hold_flag_o,
    output logic              jump_flag_o,
    output logic [31:0]       jump_addr_o,
    output logic              flush_active_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    localparam logic [HOLD_W-1:0] HOLD_NONE = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_PC   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_IF   = HOLD_W'(2);
    localparam logic [HOLD_W-1:0] HOLD_ID   = HOLD_W'(3);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic [HOLD_W-1:0]  hold;
    logic               jump_acc;

    // Everything is qualified by rst so that inputs (possibly X) cannot
    // reach the outputs or counters while reset is held.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold        = HOLD_NONE;
        jump_flag_o = 1'b0;
        jump_addr_o = 32'd0;
        jump_acc    = 1'b0;
        if (rst) begin
            if (jump_flag_i) begin
                jump_acc    = 1'b1;
                jump_flag_o = 1'b1;
                jump_addr_o = jump_addr_i;
                hold        = HOLD_ID;
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                end else begin
                    state_d = ST_RUN;
                end
            end else if (ex_busy_i) begin
                hold    = HOLD_ID;
                state_d = ST_BUSY;
            end else if (state_q == ST_FLUSH) begin
                // bus_hold_i is irrelevant here: the front end is already frozen
                hold  = HOLD_IF;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = ST_RUN;
                end
            end else begin
                // Covers both RUN and the BUSY exit cycle
                hold    = bus_hold_i ? HOLD_PC : HOLD_NONE;
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (hold != HOLD_NONE && stall_q != {CNT_W{1'b1}}) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (jump_acc && flush_q != {CNT_W{1'b1}}) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign hold_flag_o    = hold;
    assign flush_active_o = rst && (state_q == ST_FLUSH);
    assign stall_cnt_o    = stall_q;
    assign flush_cnt_o    = flush_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
module tb_pipe_hold_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        ex_busy_i;
    logic        bus_hold_i;

    logic [2:0]  hold_flag_o,    s_hold;
    logic        jump_flag_o,    s_jf;
    logic [31:0] jump_addr_o,    s_ja;
    logic        flush_active_o, s_fa;
    logic [31:0] stall_cnt_o,    flush_cnt_o;
    logic [3:0]  s_stall,        s_flush;

    pipe_hold_ctrl #(.HOLD_W(3), .FLUSH_CYCLES(2), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .ex_busy_i(ex_busy_i), .bus_hold_i(bus_hold_i),
        .hold_flag_o(hold_flag_o), .jump_flag_o(jump_flag_o),
        .jump_addr_o(jump_addr_o), .flush_active_o(flush_active_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // Narrow-counter build on the same stimulus to exercise saturation
    pipe_hold_ctrl #(.HOLD_W(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .ex_busy_i(ex_busy_i), .bus_hold_i(bus_hold_i),
        .hold_flag_o(s_hold), .jump_flag_o(s_jf),
        .jump_addr_o(s_ja), .flush_active_o(s_fa),
        .stall_cnt_o(s_stall), .flush_cnt_o(s_flush)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  hold;
        logic        jf;
        logic [31:0] ja;
        logic        fa;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t sb[$];
    int unsigned tot_stall = 0;
    int unsigned tot_flush = 0;

    function automatic logic [3:0] sat4(input int unsigned v);
        return (v > 15) ? 4'd15 : v[3:0];
    endfunction

    // Drive one cycle's inputs just after the edge; push what the outputs
    // must be in that cycle, counters showing all earlier cycles.
    task automatic step(input string tag, input logic j, input logic [31:0] a,
                        input logic b, input logic bh,
                        input logic [2:0] eh, input logic efa);
        exp_t e;
        @(posedge clk);
        #1;
        jump_flag_i = j;
        jump_addr_i = a;
        ex_busy_i   = b;
        bus_hold_i  = bh;
        e.tag   = tag;
        e.hold  = eh;
        e.jf    = j;
        e.ja    = j ? a : 32'd0;
        e.fa    = efa;
        e.stall = tot_stall;
        e.flush = tot_flush;
        sb.push_back(e);
        if (eh != 3'd0) tot_stall++;
        if (j) tot_flush++;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, ".hold"},  hold_flag_o,    e.hold);
            check({e.tag, ".jf"},    jump_flag_o,    e.jf);
            check({e.tag, ".ja"},    jump_addr_o,    e.ja);
            check({e.tag, ".fa"},    flush_active_o, e.fa);
            check({e.tag, ".stall"}, stall_cnt_o,    e.stall);
            check({e.tag, ".flush"}, flush_cnt_o,    e.flush);
            check({e.tag, ".sat_stall"}, s_stall, sat4(e.stall));
            check({e.tag, ".sat_flush"}, s_flush, sat4(e.flush));
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'hDEAD_BEEF;
        ex_busy_i   = 1'b1;
        bus_hold_i  = 1'b1;
        #13;
        check("rst.hold",  hold_flag_o, 0);
        check("rst.jf",    jump_flag_o, 0);
        check("rst.ja",    jump_addr_o, 0);
        check("rst.stall", stall_cnt_o, 0);
        check("rst.flush", flush_cnt_o, 0);
        jump_flag_i = 1'b0; jump_addr_i = '0; ex_busy_i = 1'b0; bus_hold_i = 1'b0;
        #3 rst = 1'b1;

        step("idle0", 0, 0, 0, 0, 3'd0, 0);
        step("idle1", 0, 0, 0, 0, 3'd0, 0);

        // single jump
        step("j1.n0", 1, 32'h100, 0, 0, 3'd3, 0);
        step("j1.n1", 0, 0,       0, 0, 3'd2, 1);
        step("j1.n2", 0, 0,       0, 0, 3'd0, 0);

        // back-to-back jumps; the second restarts the flush
        step("bb.n0", 1, 32'h100, 0, 0, 3'd3, 0);
        step("bb.n1", 1, 32'h200, 0, 0, 3'd3, 1);
        step("bb.n2", 0, 0,       0, 0, 3'd2, 1);
        step("bb.n3", 0, 0,       0, 0, 3'd0, 0);

        // multi-cycle op ending in a jump
        for (int i = 0; i < 5; i++) step("mc.busy", 0, 0, 1, 0, 3'd3, 0);
        step("mc.jump",  1, 32'h44, 0, 0, 3'd3, 0);
        step("mc.flush", 0, 0,      0, 0, 3'd2, 1);
        step("mc.done",  0, 0,      0, 0, 3'd0, 0);

        // busy falling with bus hold in the same cycle
        step("bf.b0", 0, 0, 1, 0, 3'd3, 0);
        step("bf.b1", 0, 0, 1, 1, 3'd3, 0);
        step("bf.fall", 0, 0, 0, 1, 3'd1, 0);
        step("bf.run",  0, 0, 0, 0, 3'd0, 0);

        // bus hold in RUN
        for (int i = 0; i < 3; i++) step("bh.run", 0, 0, 0, 1, 3'd1, 0);
        step("bh.rel", 0, 0, 0, 0, 3'd0, 0);

        // bus hold ignored in FLUSH
        step("bhf.j",   1, 32'h300, 0, 1, 3'd3, 0);
        step("bhf.fl",  0, 0,       0, 1, 3'd2, 1);
        step("bhf.run", 0, 0,       0, 1, 3'd1, 0);
        step("bhf.end", 0, 0,       0, 0, 3'd0, 0);

        // jump beats busy; busy beats FLUSH
        step("pri.jb",  1, 32'h400, 1, 1, 3'd3, 0);
        step("pri.bf",  0, 0,       1, 0, 3'd3, 1);
        step("pri.end", 0, 0,       0, 0, 3'd0, 0);

        // async reset mid-BUSY
        step("ar.busy", 0, 0, 1, 0, 3'd3, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("ar.hold",  hold_flag_o, 0);
        check("ar.stall", stall_cnt_o, 0);
        check("ar.flush", flush_cnt_o, 0);
        check("ar.sat",   s_stall,     0);
        ex_busy_i = 1'b0;
        #10 rst = 1'b1;
        tot_stall = 0;
        tot_flush = 0;
        step("ar.run0", 0, 0, 0, 0, 3'd0, 0);
        step("ar.bus",  0, 0, 0, 1, 3'd1, 0);
        step("ar.run1", 0, 0, 0, 0, 3'd0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
